// File: rtl/cordic_dot_product_seq.sv
// Dot-product sequencer that feeds operand pairs to cordic_multiply one at a time
// and accumulates the returned products, returning a WL-bit saturated result.
module cordic_dot_product_seq #(
  parameter int WL     = 16,
  parameter int FL     = 14,
  parameter int LEN_W  = 4,
  parameter int ACC_WL = WL + LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [WL-1:0]    a_in,
  input  logic [WL-1:0]    b_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             mul_start,
  output logic [WL-1:0]    mul_in1,
  output logic [WL-1:0]    mul_in2,
  input  logic [WL-1:0]    mul_out,
  input  logic             mul_done,
  output logic [WL-1:0]    result,
  output logic             sat,
  output logic             done,
  output logic             busy
);

  // The binary point only matters to the multiplier; products arrive already aligned.
  if (FL < 0 || FL >= WL) begin : g_fl_out_of_range
  end

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, ACC, FIN} state_t;

  localparam logic signed [ACC_WL-1:0] POS_MAX = {{(ACC_WL-WL+1){1'b0}}, {(WL-1){1'b1}}};
  localparam logic signed [ACC_WL-1:0] NEG_MIN = {{(ACC_WL-WL+1){1'b1}}, {(WL-1){1'b0}}};

  state_t                    state, state_nxt;
  logic [LEN_W-1:0]          count;
  logic signed [ACC_WL-1:0]  acc, acc_sum, acc_fin;
  logic [WL-1:0]             prod_r;
  logic                      mul_done_q, mul_rise;
  logic [WL-1:0]             res_nxt;
  logic                      sat_nxt;

  // Edge detect makes pulse-style and held-level multiplier done look the same.
  assign mul_rise  = mul_done & ~mul_done_q;
  assign acc_sum   = acc + {{(ACC_WL-WL){prod_r[WL-1]}}, prod_r};

  assign in_ready  = (state == FETCH);
  assign mul_start = (state == ISSUE);
  assign done      = (state == FIN);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len == '0) ? FIN : FETCH;
      FETCH:   if (in_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (mul_rise) state_nxt = ACC;
      ACC:     state_nxt = (count == LEN_W'(1)) ? FIN : FETCH;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Result is registered on the edge entering FIN so it is valid alongside done.
  always_comb begin
    acc_fin = (state == ACC) ? acc_sum : '0;
    res_nxt = acc_fin[WL-1:0];
    sat_nxt = 1'b0;
    if (acc_fin > POS_MAX) begin
      res_nxt = {1'b0, {(WL-1){1'b1}}};
      sat_nxt = 1'b1;
    end else if (acc_fin < NEG_MIN) begin
      res_nxt = {1'b1, {(WL-1){1'b0}}};
      sat_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      acc        <= '0;
      prod_r     <= '0;
      mul_in1    <= '0;
      mul_in2    <= '0;
      mul_done_q <= 1'b0;
      result     <= '0;
      sat        <= 1'b0;
    end else begin
      state      <= state_nxt;
      mul_done_q <= mul_done;
      if (state == IDLE && start) begin
        count <= len;
        acc   <= '0;
      end
      if (state == FETCH && in_valid) begin
        mul_in1 <= a_in;
        mul_in2 <= b_in;
      end
      if (state == WAIT && mul_rise) prod_r <= mul_out;
      if (state == ACC) begin
        acc   <= acc_sum;
        count <= count - 1'b1;
      end
      if (state_nxt == FIN) begin
        result <= res_nxt;
        sat    <= sat_nxt;
      end
    end
  end

endmodule

// File: tb/tb_cordic_dot_product_seq.sv
// Randomized self-checking bench for cordic_dot_product_seq with a behavioural
// 16-cycle multiplier and a plain-arithmetic dot-product reference.
module tb_cordic_dot_product_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  len = '0;
  logic [15:0] a_in = '0, b_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, mul_start, sat, done, busy;
  logic [15:0] mul_in1, mul_in2, result;
  logic [15:0] mul_out = '0;
  logic        mul_done = 1'b0;

  int checks = 0, errors = 0;
  int n_mstart = 0, n_done = 0;
  int m_cnt = 0;
  logic [15:0] m_p = '0;
  logic [15:0] va [16];
  logic [15:0] vb [16];

  cordic_dot_product_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .a_in(a_in), .b_in(b_in),
    .in_valid(in_valid), .in_ready(in_ready), .mul_start(mul_start),
    .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_out(mul_out), .mul_done(mul_done),
    .result(result), .sat(sat), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mprod(input logic signed [15:0] a, input logic signed [15:0] b);
    logic signed [31:0] p;
    p = a * b;
    return 16'(p >>> 14);
  endfunction

  // Multiplier model: fixed latency, done held high until the next start.
  always @(posedge clk) begin
    if (mul_start) begin
      mul_done <= 1'b0;
      m_p      <= mprod(mul_in1, mul_in2);
      m_cnt    <= 16;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        mul_done <= 1'b1;
        mul_out  <= m_p;
      end
    end
  end

  always @(posedge mul_start) n_mstart++;
  always @(posedge done) n_done++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input int n);
    @(negedge clk); start = 1'b1; len = 4'(n);
    @(negedge clk); start = 1'b0;
  endtask

  task automatic feed(input int i);
    int k = 0;
    a_in = va[i]; b_in = vb[i]; in_valid = 1'b1;
    while (!in_ready && k < 200) begin @(negedge clk); k++; end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic run(input string tag, input int n, input int stall_at);
    int ms0, d0, k;
    longint acc;
    logic [15:0] er;
    logic es;
    ms0 = n_mstart; d0 = n_done;
    acc = 0;
    for (int i = 0; i < n; i++) acc += longint'($signed(mprod(va[i], vb[i])));
    if (acc > 32767) begin er = 16'h7FFF; es = 1'b1; end
    else if (acc < -32768) begin er = 16'h8000; es = 1'b1; end
    else begin er = acc[15:0]; es = 1'b0; end

    do_start(n);
    if (n == 0) chk({tag, "_len0_lat"}, {31'b0, done}, 1);
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        k = 0;
        while (!in_ready && k < 200) begin @(negedge clk); k++; end
        for (int s = 0; s < 5; s++) begin
          chk({tag, "_stall_rdy"}, {31'b0, in_ready}, 1);
          chk({tag, "_stall_mstart"}, {31'b0, mul_start}, 0);
          start = (s == 2);
          len = 4'hF;
          @(negedge clk);
        end
        start = 1'b0;
      end
      feed(i);
    end
    k = 0;
    while (!done && k < 2000) begin @(negedge clk); k++; end
    chk({tag, "_done"}, {31'b0, done}, 1);
    chk({tag, "_result"}, {16'b0, result}, {16'b0, er});
    chk({tag, "_sat"}, {31'b0, sat}, {31'b0, es});
    chk({tag, "_busy_fin"}, {31'b0, busy}, 1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'b0, done}, 0);
    chk({tag, "_busy_after"}, {31'b0, busy}, 0);
    chk({tag, "_n_done"}, n_done - d0, 1);
    chk({tag, "_n_mstart"}, n_mstart - ms0, n);
    repeat (3) @(negedge clk);
    chk({tag, "_result_held"}, {16'b0, result}, {16'b0, er});
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_result"}, {16'b0, result}, 0);
    chk({tag, "_sat"}, {31'b0, sat}, 0);
    chk({tag, "_done"}, {31'b0, done}, 0);
    chk({tag, "_busy"}, {31'b0, busy}, 0);
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 0);
    chk({tag, "_mul_start"}, {31'b0, mul_start}, 0);
    chk({tag, "_mul_in"}, {mul_in1, mul_in2}, 0);
  endtask

  initial begin
    int d0, ms0, n;
    repeat (3) @(negedge clk);
    check_idle_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin va[i] = 16'h2000; vb[i] = 16'h2000; end
    run("len4", 4, -1);

    va[0] = 16'h2000; vb[0] = 16'h2000;
    va[1] = 16'h2000; vb[1] = 16'hE000;
    va[2] = 16'h3000; vb[2] = 16'h2000;
    run("mixed", 3, -1);
    run("stall", 3, 1);

    va[0] = 16'h7FFF; vb[0] = 16'h4000; va[1] = 16'h7FFF; vb[1] = 16'h4000;
    run("sat_pos", 2, -1);
    vb[0] = 16'hC000; vb[1] = 16'hC000;
    run("sat_neg", 2, -1);

    run("len0", 0, -1);

    // Abort during the second multiply; the model's late done must be ignored.
    va[0] = 16'h2000; vb[0] = 16'h2000; va[1] = 16'h1000; vb[1] = 16'h1000;
    va[2] = 16'h1000; vb[2] = 16'h1000;
    d0 = n_done;
    do_start(3);
    feed(0);
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    feed(1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_zero("abort");
    rst_n = 1'b1;
    ms0 = n_mstart;
    repeat (25) @(negedge clk);
    chk("abort_no_done", n_done - d0, 0);
    chk("abort_no_mstart", n_mstart - ms0, 0);
    chk("abort_busy", {31'b0, busy}, 0);
    run("post_rst", 1, -1);

    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(0, 15);
      for (int i = 0; i < 16; i++) begin
        if (r % 3 == 0) begin
          va[i] = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
          vb[i] = 16'($urandom_range(16'h3000, 16'h7FFF));
        end else begin
          va[i] = 16'($urandom);
          vb[i] = 16'($urandom);
        end
      end
      run($sformatf("rand%0d", r), n, $urandom_range(0, 16));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
